// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state, Booth op codes and default width for the multdiv unit
package multdiv_pkg;
  localparam int MULT_WIDTH = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB} booth_op_t;
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    return (q0 == qm1) ? BOOTH_NOP : (q0 ? BOOTH_SUB : BOOTH_ADD);
  endfunction
endpackage

// File: rtl/booth_addsub33.sv
// booth_addsub33: combinational add/subtract, subtraction as invert-plus-carry-in
module booth_addsub33 #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  assign sum = a + (b ^ {W{sub}}) + W'(sub);
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth signed multiplier, low WIDTH product bits plus overflow flag
module booth_mult_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  state_t           state;
  booth_op_t        op;
  logic [WIDTH:0]   acc, m, sum, acc_n, acc_s;
  logic [WIDTH-1:0] q, q_s;
  logic             qm1, last;
  logic [CNT_W-1:0] cnt;
  assign op = booth_decode(q[0], qm1);
  booth_addsub33 #(.W(WIDTH + 1)) u_addsub (
    .a   (acc),
    .b   (m),
    .sub (op == BOOTH_SUB),
    .sum (sum)
  );
  // one extra accumulator bit keeps -M exact for the most negative multiplicand
  assign acc_n = (op == BOOTH_NOP) ? acc : sum;
  assign acc_s = {acc_n[WIDTH], acc_n[WIDTH:1]};
  assign q_s   = {acc_n[0], q[WIDTH-1:1]};
  assign last  = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      acc            <= '0;
      m              <= '0;
      q              <= '0;
      qm1            <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_mult) begin
        state <= ST_RUN;
        m     <= {data_operandA[WIDTH-1], data_operandA};
        acc   <= '0;
        q     <= data_operandB;
        qm1   <= 1'b0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (state == ST_RUN) begin
        acc <= acc_s;
        q   <= q_s;
        qm1 <= q[0];
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          state          <= ST_DONE;
          data_result    <= q_s;
          // product fits only if the upper word is pure sign extension of the lower
          data_exception <= acc_s[WIDTH-1:0] != {WIDTH{q_s[WIDTH-1]}};
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end
endmodule
